// File: rtl/jtsdram_snd_mon.sv
// Audio status tone decoder for the SDRAM tester: recovers the per-line counter
// step (1 = memory OK, 3 = memory bad) and reports lock, pass/fail and line counts.
module jtsdram_snd_mon #(
    parameter int LOCK_LINES   = 4,
    parameter int MISS_LINES   = 3,
    parameter int SILENT_LINES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        LHBL,
    input  logic [15:0] snd,
    output logic        locked,
    output logic        bad_det,
    output logic        silent,
    output logic        fmt_err,
    output logic [15:0] ok_cnt,
    output logic [15:0] bad_cnt,
    output logic [4:0]  last_step
);

    typedef enum logic [1:0] {ACQ, HUNT, LOCK, SILENT} state_t;

    localparam logic [7:0] LOCK_N   = 8'(LOCK_LINES);
    localparam logic [7:0] MISS_N   = 8'(MISS_LINES);
    localparam logic [7:0] SILENT_N = 8'(SILENT_LINES);

    state_t      r_state, w_state_nxt;
    logic        r_last_lhbl;
    logic [4:0]  r_prev, w_prev_nxt;
    logic [4:0]  r_run_step, w_run_step_nxt;
    logic [7:0]  r_run, w_run_nxt;
    logic [7:0]  r_miss, w_miss_nxt;
    logic [7:0]  r_zero, w_zero_nxt;
    logic        r_bad_det, w_bad_det_nxt;
    logic        r_fmt_err, w_fmt_err_nxt;
    logic [15:0] r_ok_cnt, w_ok_cnt_nxt;
    logic [15:0] r_bad_cnt, w_bad_cnt_nxt;
    logic [4:0]  r_last_step, w_last_step_nxt;

    logic        w_rise;
    logic        w_valid;
    logic [4:0]  w_cur;
    logic [4:0]  w_step;
    logic        w_step_ok;

    assign w_rise    = LHBL & ~r_last_lhbl;
    assign w_cur     = snd[15:11];
    assign w_valid   = (snd[15:11] == snd[10:6]) && (snd[10:6] == snd[5:1]) && (snd[0] == snd[1]);
    assign w_step    = w_cur - r_prev;
    assign w_step_ok = (w_step == 5'd1) || (w_step == 5'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ACQ;
            r_last_lhbl <= 1'b0;
            r_prev      <= '0;
            r_run_step  <= '0;
            r_run       <= '0;
            r_miss      <= '0;
            r_zero      <= '0;
            r_bad_det   <= 1'b0;
            r_fmt_err   <= 1'b0;
            r_ok_cnt    <= '0;
            r_bad_cnt   <= '0;
            r_last_step <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_last_lhbl <= LHBL;
            r_prev      <= w_prev_nxt;
            r_run_step  <= w_run_step_nxt;
            r_run       <= w_run_nxt;
            r_miss      <= w_miss_nxt;
            r_zero      <= w_zero_nxt;
            r_bad_det   <= w_bad_det_nxt;
            r_fmt_err   <= w_fmt_err_nxt;
            r_ok_cnt    <= w_ok_cnt_nxt;
            r_bad_cnt   <= w_bad_cnt_nxt;
            r_last_step <= w_last_step_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_prev_nxt      = r_prev;
        w_run_step_nxt  = r_run_step;
        w_run_nxt       = r_run;
        w_miss_nxt      = r_miss;
        w_zero_nxt      = r_zero;
        w_bad_det_nxt   = r_bad_det;
        w_fmt_err_nxt   = r_fmt_err;
        w_ok_cnt_nxt    = r_ok_cnt;
        w_bad_cnt_nxt   = r_bad_cnt;
        w_last_step_nxt = r_last_step;
        if (w_rise && !w_valid) begin
            w_fmt_err_nxt = 1'b1;
            w_zero_nxt    = '0;
            if (r_state == HUNT) begin
                w_run_nxt = '0;
            end else if (r_state == LOCK) begin
                w_miss_nxt = r_miss + 8'd1;
                if (w_miss_nxt >= MISS_N) begin
                    w_state_nxt   = HUNT;
                    w_bad_det_nxt = 1'b0;
                    w_run_nxt     = '0;
                    w_miss_nxt    = '0;
                end
            end
        end else if (w_rise) begin
            w_prev_nxt = w_cur;
            if (w_cur == 5'd0)
                w_zero_nxt = (r_zero >= SILENT_N) ? r_zero : r_zero + 8'd1;
            else
                w_zero_nxt = '0;
            case (r_state)
                ACQ: begin
                    w_state_nxt = HUNT;
                    w_run_nxt   = '0;
                end
                SILENT: begin
                    if (w_cur != 5'd0) begin
                        w_state_nxt = HUNT;
                        w_run_nxt   = '0;
                    end
                end
                HUNT: begin
                    w_last_step_nxt = w_step;
                    if (w_step_ok) begin
                        w_run_nxt      = (r_run == 8'd0 || w_step == r_run_step) ? r_run + 8'd1 : 8'd1;
                        w_run_step_nxt = w_step;
                        if (w_run_nxt >= LOCK_N) begin
                            w_state_nxt   = LOCK;
                            w_bad_det_nxt = (w_step == 5'd3);
                            w_miss_nxt    = '0;
                        end
                    end else begin
                        w_run_nxt = '0;
                    end
                end
                default: begin
                    w_last_step_nxt = w_step;
                    if (w_step == 5'd1) begin
                        w_ok_cnt_nxt  = (r_ok_cnt == '1) ? r_ok_cnt : r_ok_cnt + 16'd1;
                        w_bad_det_nxt = 1'b0;
                        w_miss_nxt    = '0;
                    end else if (w_step == 5'd3) begin
                        w_bad_cnt_nxt = (r_bad_cnt == '1) ? r_bad_cnt : r_bad_cnt + 16'd1;
                        w_bad_det_nxt = 1'b1;
                        w_miss_nxt    = '0;
                    end else begin
                        w_miss_nxt = r_miss + 8'd1;
                        if (w_miss_nxt >= MISS_N) begin
                            w_state_nxt   = HUNT;
                            w_bad_det_nxt = 1'b0;
                            w_run_nxt     = '0;
                            w_miss_nxt    = '0;
                        end
                    end
                end
            endcase
            // Silence wins over whatever the state logic above decided
            if (w_zero_nxt >= SILENT_N) begin
                w_state_nxt   = SILENT;
                w_bad_det_nxt = 1'b0;
                w_run_nxt     = '0;
                w_miss_nxt    = '0;
            end
        end
    end

    always_comb begin
        locked    = (r_state == LOCK);
        silent    = (r_state == SILENT);
        bad_det   = r_bad_det;
        fmt_err   = r_fmt_err;
        ok_cnt    = r_ok_cnt;
        bad_cnt   = r_bad_cnt;
        last_step = r_last_step;
    end

endmodule

// File: doc/jtsdram_snd_mon.md
Name: jtsdram_snd_mon

Overview:
- Decoder for the SDRAM tester's audio status tone.
- Watches the 16-bit tone stream produced on each line and recovers the per-line counter step: step 1 means memory OK, step 3 means memory bad.
- Reports lock and pass/fail status plus line counters for on-screen display and self-check benches.
- Sits beside the tone generator, fed by the same clk and LHBL.

Parameters:
- LOCK_LINES, 4: consecutive matching steps needed to lock.
- MISS_LINES, 3: consecutive unexpected steps while locked before dropping lock.
- SILENT_LINES, 8: consecutive zero samples to declare silence (download in progress).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- LHBL  in  1  horizontal blank, active low; rising edge marks line start
- snd  in  16  tone sample
- locked  out  1  tone recognised (state LOCK)
- bad_det  out  1  locked tone indicates failure (step 3)
- silent  out  1  state SILENT
- fmt_err  out  1  sticky: malformed sample seen
- ok_cnt  out  16  locked lines with step 1, saturating
- bad_cnt  out  16  locked lines with step 3, saturating
- last_step  out  5  most recent computed step

Behaviour:
- Reset (rst=1 at a clk edge): every output 0; state ACQ; internal prev, run, miss and zero counters 0; last_LHBL 0.
- Edge detect:
  - last_LHBL is registered every cycle.
  - rise = LHBL & ~last_LHBL.
  - All processing happens only on rise cycles. Between rises all state holds.
- Sampling: on a rise cycle, cur = snd[15:11] as seen that cycle.
- Format check:
  - Sample is valid iff snd[15:11]==snd[10:6]==snd[5:1] and snd[0]==snd[1].
  - An invalid sample sets fmt_err (cleared only by rst).
  - An invalid sample does not update prev or last_step.
  - It counts as a miss in LOCK, clears run in HUNT, and clears the zero counter.
- Step arithmetic: step = (cur - prev) mod 32, 5-bit wrap. Example: 31→0 gives 1; 30→1 gives 3.
  - last_step <= step on every valid rise outside ACQ/SILENT entry.
  - prev <= cur on every valid rise.
- Silence tracking:
  - Valid cur==0 increments the zero counter, saturating at SILENT_LINES; a nonzero sample clears it.
  - When the counter reaches SILENT_LINES, from any state, go to SILENT on that rise: locked=0, bad_det=0, silent=1.
- ACQ:
  - First valid rise loads prev and goes to HUNT with run=0. No step is computed.
- HUNT:
  - step ∈ {1,3} and (run==0 or step==run_step): run++ and run_step=step.
  - step ∈ {1,3} but differs from run_step: run=1 and run_step=step.
  - Any other step: run=0.
  - When run reaches LOCK_LINES: go to LOCK on that rise, locked=1, bad_det=(run_step==3), miss=0. Counters are not incremented on the lock-entering line.
- LOCK:
  - step==1: ok_cnt++, bad_det=0, miss=0.
  - step==3: bad_cnt++, bad_det=1, miss=0.
  - Flips between 1 and 3 take effect on that same line without losing lock.
  - Other step or invalid sample: miss++. When miss reaches MISS_LINES: go to HUNT, locked=0, bad_det=0, run=0.
- SILENT:
  - First valid nonzero sample: go to HUNT with prev=cur, silent=0, run=0, zero counter 0.
- Counters: 16-bit, hold at 0xFFFF.
- Outputs are registered and update the cycle after the rise edge.
- rst mid-line or mid-lock: immediate return to the reset state; counters are cleared.
- A rise coinciding with rst is ignored.

Test Plan:
- Valid tone incrementing by 1 per line from 0 (snd per format, pre=n) → locked=1 after the 5th rise (1 ACQ + 4 steps), bad_det=0, ok_cnt increments from the 6th rise, last_step=1.
- Locked on step 1, then switch to step 3 for 10 lines → bad_det=1 on the first step-3 line, locked stays 1, bad_cnt=10, ok_cnt frozen.
- Wrap: pre sequence 29,0,3,6,9,12 (step 3 across 29→0) → lock with bad_det=1, and the 29→0 wrap is accepted as step 3.
- Locked, then 3 lines with step 7 → locked=0 on the 3rd; 2 bad lines followed by a good one → stays locked, miss clears.
- snd=0x0000 for 8 rises (download shifting to zero) → silent=1 on the 8th, locked=0; next valid pre=5 → silent=0, state HUNT.
- Sample 0x8000 (mismatched copies) → fmt_err=1 and sticky, prev unchanged; rst mid-lock → all outputs 0 the next cycle.
